// File: rtl/r22sdf_twiddle_mult.sv
// Inter-stage twiddle rotator for an R2^2 SDF pipeline.
// Multiplies each streamed sample by W_N^e, where e is derived from a
// free-running sample counter aligned to the upstream stage's output order.
// Three enabled cycles of latency: ROM/input register, products, round+saturate.
module r22sdf_twiddle_mult #(
    parameter int data_resolution    = 16,
    parameter int twiddle_resolution = 16,
    parameter int fft_points         = 16,
    parameter int delay_tick         = 0
) (
    input  logic                              sys_clk,
    input  logic                              sys_nrst,
    input  logic                              sys_en,
    input  logic signed [data_resolution-1:0] din_r,
    input  logic signed [data_resolution-1:0] din_i,
    output logic signed [data_resolution-1:0] dout_r,
    output logic signed [data_resolution-1:0] dout_i,
    output logic                              dout_sof
);

    localparam int DR        = data_resolution;
    localparam int TR        = twiddle_resolution;
    localparam int N         = fft_points;
    localparam int T_W       = $clog2(N);
    localparam int R_W       = T_W - 2;
    localparam int ROM_DEPTH = 3 * N / 4;
    localparam int P_W       = DR + TR;
    localparam int S_W       = P_W + 1;

    // Counter start value so that t==0 lines up with the upstream frame start.
    localparam logic [T_W-1:0] T_RST = T_W'((N - (delay_tick % N)) % N);

    localparam logic signed [S_W-1:0] RND     = S_W'(1) <<< (TR - 3);
    localparam logic signed [S_W-1:0] SAT_MAX = (S_W'(1) <<< (DR - 1)) - S_W'(1);
    localparam logic signed [S_W-1:0] SAT_MIN = -SAT_MAX - S_W'(1);

    // Twiddle coefficient scaled so that unity is 2^(TR-2); symmetric rounding.
    function automatic logic signed [TR-1:0] tw_coef(input int idx, input bit is_sin);
        real ang;
        real v;
        ang = 2.0 * 3.14159265358979323846 * real'(idx) / real'(N);
        v   = is_sin ? -$sin(ang) : $cos(ang);
        v   = v * real'(2 ** (TR - 2));
        if (v >= 0.0) return TR'($rtoi(v + 0.5));
        else          return TR'(-$rtoi(0.5 - v));
    endfunction

    function automatic logic signed [DR-1:0] sat(input logic signed [S_W-1:0] x);
        if (x > SAT_MAX)      return DR'(SAT_MAX);
        else if (x < SAT_MIN) return DR'(SAT_MIN);
        else                  return DR'(x);
    endfunction

    // Elaboration-time twiddle ROM
    logic signed [TR-1:0] rom_cr [ROM_DEPTH];
    logic signed [TR-1:0] rom_ci [ROM_DEPTH];

    for (genvar k = 0; k < ROM_DEPTH; k++) begin : g_rom
        localparam logic signed [TR-1:0] CR = tw_coef(k, 1'b0);
        localparam logic signed [TR-1:0] CI = tw_coef(k, 1'b1);
        assign rom_cr[k] = CR;
        assign rom_ci[k] = CI;
    end

    // Sample counter and exponent
    logic [T_W-1:0] t;
    logic [1:0]     q;
    logic [1:0]     q_rev;
    logic [R_W-1:0] r;
    logic [T_W-1:0] e;

    // Free-running sample index, only sys_en advances it.
    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst)   t <= T_RST;
        else if (sys_en) t <= t + 1'b1;
    end

    // Quadrant is bit-reversed because the radix-2^2 stage emits sub-sequences
    // in bit-reversed quadrant order.
    assign q     = t[T_W-1 -: 2];
    assign q_rev = {q[0], q[1]};
    assign r     = t[R_W-1:0];
    assign e     = T_W'(r) * T_W'(q_rev);

    // Stage 1: input sample and coefficient
    logic signed [DR-1:0] s1_r, s1_i;
    logic signed [TR-1:0] s1_cr, s1_ci;
    logic                 s1_sof;

    // Capture the sample together with the coefficient for its index.
    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            s1_r   <= '0;
            s1_i   <= '0;
            s1_cr  <= '0;
            s1_ci  <= '0;
            s1_sof <= 1'b0;
        end else if (sys_en) begin
            s1_r   <= din_r;
            s1_i   <= din_i;
            s1_cr  <= rom_cr[e];
            s1_ci  <= rom_ci[e];
            s1_sof <= (t == '0);
        end
    end

    // Stage 2: full-precision partial products
    logic signed [P_W-1:0] p_rr, p_ii, p_ri, p_ir;
    logic                  s2_sof;

    // Four independent signed multiplies.
    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            p_rr   <= '0;
            p_ii   <= '0;
            p_ri   <= '0;
            p_ir   <= '0;
            s2_sof <= 1'b0;
        end else if (sys_en) begin
            p_rr   <= P_W'(s1_r) * P_W'(s1_cr);
            p_ii   <= P_W'(s1_i) * P_W'(s1_ci);
            p_ri   <= P_W'(s1_r) * P_W'(s1_ci);
            p_ir   <= P_W'(s1_i) * P_W'(s1_cr);
            s2_sof <= s1_sof;
        end
    end

    // Stage 3: combine, round half up, saturate
    logic signed [S_W-1:0] sum_r, sum_i, rnd_r, rnd_i;

    assign sum_r = S_W'(p_rr) - S_W'(p_ii);
    assign sum_i = S_W'(p_ri) + S_W'(p_ir);
    assign rnd_r = (sum_r + RND) >>> (TR - 2);
    assign rnd_i = (sum_i + RND) >>> (TR - 2);

    // Output register; unity coefficient passes data through exactly.
    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            dout_r   <= '0;
            dout_i   <= '0;
            dout_sof <= 1'b0;
        end else if (sys_en) begin
            dout_r   <= sat(rnd_r);
            dout_i   <= sat(rnd_i);
            dout_sof <= s2_sof;
        end
    end

endmodule

// File: tb/tb_r22sdf_twiddle_mult.sv
// Self-checking bench: two instances (delay_tick 0 and 3) share stimulus and
// are compared against a behavioural rotate-by-W_N^e model.
module tb_r22sdf_twiddle_mult;

    localparam int DR = 16;
    localparam int TR = 16;
    localparam int N  = 16;

    logic sys_clk  = 1'b0;
    logic sys_nrst = 1'b1;
    logic sys_en   = 1'b0;
    logic signed [DR-1:0] din_r = '0;
    logic signed [DR-1:0] din_i = '0;
    logic signed [DR-1:0] a_r, a_i, b_r, b_i;
    logic a_sof, b_sof;

    int checks = 0;
    int errors = 0;
    int ecnt;
    int tcnt [2];
    int m_r  [2][3];
    int m_i  [2][3];
    int m_s  [2][3];

    always #5 sys_clk = ~sys_clk;

    r22sdf_twiddle_mult #(.data_resolution(DR), .twiddle_resolution(TR),
                          .fft_points(N), .delay_tick(0)) dut_a (
        .sys_clk(sys_clk), .sys_nrst(sys_nrst), .sys_en(sys_en),
        .din_r(din_r), .din_i(din_i),
        .dout_r(a_r), .dout_i(a_i), .dout_sof(a_sof));

    r22sdf_twiddle_mult #(.data_resolution(DR), .twiddle_resolution(TR),
                          .fft_points(N), .delay_tick(3)) dut_b (
        .sys_clk(sys_clk), .sys_nrst(sys_nrst), .sys_en(sys_en),
        .din_r(din_r), .din_i(din_i),
        .dout_r(b_r), .dout_i(b_i), .dout_sof(b_sof));

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint rnd(input real x);
        return longint'($floor(x + 0.5));
    endfunction

    function automatic int clip(input longint x);
        if (x > 32767)  return 32767;
        if (x < -32768) return -32768;
        return int'(x);
    endfunction

    // Reference: rotate (ar,ai) by exp(-j*2*pi*e/N) in fixed point.
    task automatic rot(input int t, input int ar, input int ai, output int orr, output int oi);
        int q, r, qb, e;
        real ang;
        longint cr, ci, pr, pi;
        q  = t / (N / 4);
        r  = t % (N / 4);
        qb = (q == 1) ? 2 : (q == 2) ? 1 : q;
        e  = r * qb;
        ang = 2.0 * 3.14159265358979 * real'(e) / real'(N);
        cr = rnd($cos(ang) * 16384.0);
        ci = rnd(-$sin(ang) * 16384.0);
        pr = ar * cr - ai * ci;
        pi = ar * ci + ai * cr;
        orr = clip((pr + 8192) >>> 14);
        oi  = clip((pi + 8192) >>> 14);
    endtask

    task automatic mdl_reset();
        tcnt[0] = 0;
        tcnt[1] = N - 3;
        ecnt = 0;
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < 3; s++) begin
                m_r[d][s] = 0; m_i[d][s] = 0; m_s[d][s] = 0;
            end
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear immediately.
    task automatic do_reset();
        #2 sys_nrst = 1'b0;
        sys_en = 1'b0;
        #1;
        chk("rst_a_r", int'(a_r), 0);
        chk("rst_a_i", int'(a_i), 0);
        chk("rst_a_sof", int'(a_sof), 0);
        chk("rst_b_r", int'(b_r), 0);
        chk("rst_b_i", int'(b_i), 0);
        chk("rst_b_sof", int'(b_sof), 0);
        mdl_reset();
        @(negedge sys_clk);
        sys_nrst = 1'b1;
    endtask

    // One clock: drive at negedge, advance model on enabled edge, check after edge.
    task automatic cyc(input bit en, input int dr, input int di);
        int orr, oi;
        @(negedge sys_clk);
        sys_en = en;
        din_r  = DR'(dr);
        din_i  = DR'(di);
        @(posedge sys_clk);
        #1;
        if (en) begin
            ecnt++;
            for (int d = 0; d < 2; d++) begin
                for (int s = 2; s > 0; s--) begin
                    m_r[d][s] = m_r[d][s-1];
                    m_i[d][s] = m_i[d][s-1];
                    m_s[d][s] = m_s[d][s-1];
                end
                rot(tcnt[d], dr, di, orr, oi);
                m_r[d][0] = orr;
                m_i[d][0] = oi;
                m_s[d][0] = (tcnt[d] == 0) ? 1 : 0;
                tcnt[d] = (tcnt[d] + 1) % N;
            end
        end
        chk("a_r", int'(a_r), m_r[0][2]);
        chk("a_i", int'(a_i), m_i[0][2]);
        chk("a_sof", int'(a_sof), m_s[0][2]);
        chk("b_r", int'(b_r), m_r[1][2]);
        chk("b_i", int'(b_i), m_i[1][2]);
        chk("b_sof", int'(b_sof), m_s[1][2]);
    endtask

    function automatic int rval();
        int k;
        k = $urandom_range(0, 7);
        if (k == 0) return -32768;
        if (k == 1) return 32767;
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    initial begin
        int last_sof;

        // Constant (1000,0) stream: pass-through for q'=0, known rotations elsewhere.
        do_reset();
        for (int k = 1; k <= 18; k++) begin
            cyc(1'b1, 1000, 0);
            if (k == 3) begin
                chk("t1_sof", int'(a_sof), 1);
                chk("t1_r0", int'(a_r), 1000);
                chk("t1_i0", int'(a_i), 0);
            end
            if (k >= 3 && k <= 6) chk("t1_exact", int'(a_r), 1000);
            if (k == 8) begin
                chk("t2_r_t5", int'(a_r), 707);
                chk("t2_i_t5", int'(a_i), -707);
            end
            if (k == 18) begin
                chk("t2_r_t15", int'(a_r), -924);
                chk("t2_i_t15", int'(a_i), 383);
            end
            chk("t5_b_sof", int'(b_sof), (k == 6) ? 1 : 0);
        end

        // Saturation: -FS * (-j) at t=6.
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            if (k == 7) cyc(1'b1, -32768, 0);
            else        cyc(1'b1, rval(), rval());
            if (k == 9) begin
                chk("t3_sat_r", int'(a_r), 0);
                chk("t3_sat_i", int'(a_i), 32767);
            end
        end

        // Random data with random enable gaps; sof period in enabled cycles.
        do_reset();
        last_sof = -1;
        for (int k = 0; k < 400; k++) begin
            bit en;
            en = 1'($urandom_range(0, 1));
            cyc(en, rval(), rval());
            if (en && a_sof) begin
                if (last_sof >= 0) chk("t4_sof_period", ecnt - last_sof, 16);
                last_sof = ecnt;
            end
        end

        // Mid-frame reset with nonzero data, then the first sequence must replay.
        do_reset();
        for (int k = 1; k <= 9; k++)
            cyc(1'b1, int'($urandom_range(100, 20000)), int'($urandom_range(100, 20000)));
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b1, 1000, 0);
            if (k == 3) begin
                chk("t6_sof", int'(a_sof), 1);
                chk("t6_r0", int'(a_r), 1000);
            end
            if (k == 8) begin
                chk("t6_r_t5", int'(a_r), 707);
                chk("t6_i_t5", int'(a_i), -707);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/r22sdf_twiddle_mult.md
Name: r22sdf_twiddle_mult

Overview:
Inter-stage twiddle rotator for the R2²SDF pipeline. It sits directly downstream of one radix-2² butterfly stage (BF2I+BF2II pair) and upstream of the next. It multiplies each streamed complex sample by W_N^e, where the exponent e comes from a free-running sample counter aligned to the upstream stage's output order. It holds a local twiddle ROM and a 3-stage pipelined complex multiplier with rounding and saturation.

Parameters:
data_resolution, 16, signed width of din/dout real and imaginary parts
twiddle_resolution, 16, signed width of twiddle cos/sin coefficients; unity = 2^(twiddle_resolution-2)
fft_points, 16, sub-FFT size N handled by the upstream radix-2² stage; power of 4, >=16
delay_tick, 0, upstream latency in samples; counter reset offset for frame alignment

Ports:
sys_clk  input  1  clock, rising edge
sys_nrst  input  1  asynchronous active-low reset
sys_en  input  1  clock enable; when low, all state (counter, pipeline) holds
din_r  input  data_resolution  real part of the input sample, two's complement
din_i  input  data_resolution  imaginary part of the input sample
dout_r  output  data_resolution  real part of the rotated sample
dout_i  output  data_resolution  imaginary part of the rotated sample
dout_sof  output  1  high for one enabled cycle when dout carries frame index t=0

Behaviour:
- Reset (async, sys_nrst=0):
  - all pipeline registers, dout_r, dout_i and dout_sof go to 0.
  - the sample counter t (log2(N) bits) loads (-delay_tick) mod N.
- Counter:
  - on each sys_en=1 edge, t <= t+1, wrapping N-1 -> 0.
  - no other condition affects it.
- Exponent:
  - q = t[MSB:MSB-1], r = t mod (N/4).
  - q' = bit-reverse(q): 0->0, 1->2, 2->1, 3->3.
  - e = r*q', with range 0..3(N/4-1).
- ROM:
  - entry e holds cr = round(cos(2πe/N)·2^(tw-2)) and ci = round(-sin(2πe/N)·2^(tw-2)).
  - contents are generated at elaboration by a constant function. Depth is 3N/4; only indices reachable by e are required.
- Pipeline (advances only when sys_en=1):
  - S1: register din_r, din_i, cr, ci for the current t, and sof1 = (t==0).
  - S2: four full-precision signed products ar·cr, ai·ci, ar·ci, ai·cr, each data_resolution+twiddle_resolution bits.
  - S3: pr = ar·cr − ai·ci and pi = ar·ci + ai·cr, computed at one extra bit.
    - Add 2^(tw-3), then arithmetic shift right by tw-2 (round half up).
    - Saturate to the data_resolution signed range and register to dout; sof1 propagates to dout_sof.
- Latency: exactly 3 enabled cycles from din to dout. sys_en=0 cycles are not counted and outputs hold.
- e=0 is exact: dout equals din delayed by 3, with no rounding error and no special-case path.
- Saturation:
  - only products with magnitude above full scale clip, e.g. −FS·(−j).
  - positive clip = 2^(dr-1)−1; negative clip = −2^(dr-1).
- dout_sof asserts every N enabled cycles, exactly 3 enabled cycles after the counter reads 0.
- Reset mid-frame: the pipeline flushes to zeros immediately and the counter realigns to (-delay_tick) mod N. There is no pending-output recovery.
- There is no handshake and no backpressure; sys_en is the only flow control, shared with the upstream stage.

Test Plan:
1. N=16, delay_tick=0: after reset drive (1000,0) every cycle -> outputs for t=0..3 (q'=0) = (1000,0) exactly; dout_sof high on the 3rd enabled cycle after reset release.
2. Same stimulus, t=5 (q'=2, r=1, e=2, coef 11585/−11585) -> dout=(707,−707); t=15 (e=9, coef −15137/6270) -> dout=(−924,383).
3. Saturation: t=6 (e=4, W=−j, coef 0/−16384), din=(−32768,0) -> dout=(0,32767).
4. sys_en pattern 1,0,0,1,... random 50% -> dout identical to the gap-free run sample-for-sample; dout and dout_sof frozen while sys_en=0; dout_sof period = 16 enabled cycles.
5. delay_tick=3 -> counter starts at 13; first dout_sof occurs 3+3=6 enabled cycles after reset release.
6. Assert sys_nrst at t=9 mid-frame with nonzero data -> dout=0 and dout_sof=0 asynchronously; after release the sequence restarts exactly as in test 1.
